// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared width, FSM state encoding and trap cause constants for the PC unit
package pc_sequencer_pkg;
  localparam int DATA_WIDTH = 32;
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;
  localparam logic [3:0] CAUSE_INSTR_MISALIGN = 4'd0;
endpackage

// File: rtl/pc_sequencer_next_pc_sel.sv
// next_pc_sel: next-PC target, take and misalign computation
//   in : pc, imm, rs1, is_branch, branch_taken, is_jal, is_jalr, is_compressed
//   out: target (jump target when take, else sequential), take, misalign (jump target only)
module next_pc_sel
  import pc_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = pc_sequencer_pkg::DATA_WIDTH,
  parameter int IALIGN     = 32
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [DATA_WIDTH-1:0] rs1,
  input  logic                  is_branch,
  input  logic                  branch_taken,
  input  logic                  is_jal,
  input  logic                  is_jalr,
  input  logic                  is_compressed,
  output logic [DATA_WIDTH-1:0] target,
  output logic                  take,
  output logic                  misalign
);
  logic [DATA_WIDTH-1:0] jt;
  always_comb begin
    take     = is_jalr | is_jal | (is_branch & branch_taken);
    jt       = is_jalr ? ((rs1 + imm) & ~DATA_WIDTH'(1)) : pc + imm;
    target   = take ? jt : pc + ((IALIGN == 16 && is_compressed) ? DATA_WIDTH'(2) : DATA_WIDTH'(4));
    misalign = take & (jt[0] | ((IALIGN == 32) & jt[1]));
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered PC with next-PC select, precise misalign traps, trap entry/return and retire counter
//   in : clk, rst_n, stall, is_branch, branch_taken, is_jal, is_jalr, is_compressed, imm_out, rs1_data,
//        trap_req, trap_req_cause, trap_ret, trap_ret_pc
//   out: pc, pc_valid, trap_valid, trap_cause, trap_epc, trap_tval, instret
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                             DATA_WIDTH   = pc_sequencer_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0]          RESET_VECTOR = '0,
  parameter logic [DATA_WIDTH-1:0]          TRAP_VECTOR  = DATA_WIDTH'(32'h0000_0100),
  parameter int                             IALIGN       = 32,
  parameter int                             CNT_WIDTH    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  is_branch,
  input  logic                  branch_taken,
  input  logic                  is_jal,
  input  logic                  is_jalr,
  input  logic                  is_compressed,
  input  logic [DATA_WIDTH-1:0] imm_out,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic                  trap_req,
  input  logic [3:0]            trap_req_cause,
  input  logic                  trap_ret,
  input  logic [DATA_WIDTH-1:0] trap_ret_pc,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  pc_valid,
  output logic                  trap_valid,
  output logic [3:0]            trap_cause,
  output logic [DATA_WIDTH-1:0] trap_epc,
  output logic [DATA_WIDTH-1:0] trap_tval,
  output logic [CNT_WIDTH-1:0]  instret
);
  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] target, ret_pc;
  logic                  take, misalign, trap_ext, adv, ret, mis_trap, retire;
  next_pc_sel #(.DATA_WIDTH(DATA_WIDTH), .IALIGN(IALIGN)) u_sel (
    .pc(pc), .imm(imm_out), .rs1(rs1_data), .is_branch(is_branch), .branch_taken(branch_taken),
    .is_jal(is_jal), .is_jalr(is_jalr), .is_compressed(is_compressed),
    .target(target), .take(take), .misalign(misalign)
  );
  // trap_req outranks stall; everything else advances only when running and not stalled
  always_comb begin
    trap_ext = (state == RUN) & trap_req;
    adv      = (state == RUN) & ~trap_req & ~stall;
    ret      = adv & trap_ret;
    mis_trap = adv & ~trap_ret & misalign;
    retire   = adv & ~mis_trap;
    ret_pc   = {trap_ret_pc[DATA_WIDTH-1:2], (IALIGN == 16) & trap_ret_pc[1], 1'b0};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= BOOT;
    else state <= state_nxt;
  always_comb state_nxt = (trap_ext | mis_trap) ? TRAP : RUN;
  always_comb begin
    pc_valid   = state == RUN;
    trap_valid = state == TRAP;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc         <= RESET_VECTOR;
      trap_cause <= '0;
      trap_epc   <= '0;
      trap_tval  <= '0;
      instret    <= '0;
    end else begin
      if (trap_ext | mis_trap) begin
        pc         <= TRAP_VECTOR;
        trap_cause <= trap_ext ? trap_req_cause : CAUSE_INSTR_MISALIGN;
        trap_epc   <= pc;
        trap_tval  <= trap_ext ? '0 : target;
      end else if (ret) pc <= ret_pc;
      else if (retire) pc <= target;
      if (retire) instret <= instret + 1'b1;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer in word-aligned and compressed configurations
module tb_pc_sequencer;
  typedef struct packed {
    logic [1:0]  st;
    logic [31:0] pc;
    logic [3:0]  cause;
    logic [31:0] epc;
    logic [31:0] tval;
    logic [63:0] ir;
  } mstate_t;
  logic        clk = 0, rst_n = 0;
  logic        stall, is_branch, branch_taken, is_jal, is_jalr, is_compressed, trap_req, trap_ret;
  logic [31:0] imm_out, rs1_data, trap_ret_pc;
  logic [3:0]  trap_req_cause;
  logic [31:0] pc32, epc32, tval32, pc16, epc16, tval16;
  logic        pv32, tv32, pv16, tv16;
  logic [3:0]  tc32, tc16;
  logic [63:0] ir32;
  logic [3:0]  ir16;
  int          n_vec = 0, n_err = 0;
  mstate_t     m32, m16;
  mstate_t     q32[$], q16[$];
  always #5 clk = ~clk;
  pc_sequencer u_dut32 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .is_branch(is_branch), .branch_taken(branch_taken),
    .is_jal(is_jal), .is_jalr(is_jalr), .is_compressed(is_compressed), .imm_out(imm_out),
    .rs1_data(rs1_data), .trap_req(trap_req), .trap_req_cause(trap_req_cause), .trap_ret(trap_ret),
    .trap_ret_pc(trap_ret_pc), .pc(pc32), .pc_valid(pv32), .trap_valid(tv32), .trap_cause(tc32),
    .trap_epc(epc32), .trap_tval(tval32), .instret(ir32)
  );
  pc_sequencer #(.IALIGN(16), .CNT_WIDTH(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .is_branch(is_branch), .branch_taken(branch_taken),
    .is_jal(is_jal), .is_jalr(is_jalr), .is_compressed(is_compressed), .imm_out(imm_out),
    .rs1_data(rs1_data), .trap_req(trap_req), .trap_req_cause(trap_req_cause), .trap_ret(trap_ret),
    .trap_ret_pc(trap_ret_pc), .pc(pc16), .pc_valid(pv16), .trap_valid(tv16), .trap_cause(tc16),
    .trap_epc(epc16), .trap_tval(tval16), .instret(ir16)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic mstate_t model(input mstate_t s, input int ia);
    mstate_t     n = s;
    logic [31:0] t;
    logic        jump;
    if (s.st != 2'd1) begin
      n.st = 2'd1;
      return n;
    end
    if (trap_req) begin
      n.pc = 32'h100; n.cause = trap_req_cause; n.epc = s.pc; n.tval = 0; n.st = 2'd2;
      return n;
    end
    if (stall) return n;
    if (trap_ret) begin
      n.pc = trap_ret_pc & (ia == 32 ? ~32'h3 : ~32'h1);
      n.ir = s.ir + 1;
      return n;
    end
    jump = 1'b1;
    t    = 0;
    if (is_jalr) t = (rs1_data + imm_out) & ~32'h1;
    else if (is_jal || (is_branch && branch_taken)) t = s.pc + imm_out;
    else jump = 1'b0;
    if (jump && (ia == 32 ? t[1:0] != 2'b00 : t[0])) begin
      n.pc = 32'h100; n.cause = 0; n.epc = s.pc; n.tval = t; n.st = 2'd2;
      return n;
    end
    n.pc = jump ? t : s.pc + ((ia == 16 && is_compressed) ? 32'd2 : 32'd4);
    n.ir = s.ir + 1;
    return n;
  endfunction
  task automatic idle();
    {stall, is_branch, branch_taken, is_jal, is_jalr, is_compressed, trap_req, trap_ret} = '0;
    imm_out = 0; rs1_data = 0; trap_ret_pc = 0; trap_req_cause = 0;
  endtask
  task automatic step();
    mstate_t e;
    m32 = model(m32, 32); q32.push_back(m32);
    m16 = model(m16, 16); q16.push_back(m16);
    @(posedge clk);
    #1;
    e = q32.pop_front();
    check("d32.pc", 64'(pc32), 64'(e.pc));
    check("d32.pc_valid", 64'(pv32), 64'(e.st == 2'd1));
    check("d32.trap_valid", 64'(tv32), 64'(e.st == 2'd2));
    check("d32.cause", 64'(tc32), 64'(e.cause));
    check("d32.epc", 64'(epc32), 64'(e.epc));
    check("d32.tval", 64'(tval32), 64'(e.tval));
    check("d32.instret", ir32, e.ir);
    e = q16.pop_front();
    check("d16.pc", 64'(pc16), 64'(e.pc));
    check("d16.pc_valid", 64'(pv16), 64'(e.st == 2'd1));
    check("d16.trap_valid", 64'(tv16), 64'(e.st == 2'd2));
    check("d16.cause", 64'(tc16), 64'(e.cause));
    check("d16.epc", 64'(epc16), 64'(e.epc));
    check("d16.tval", 64'(tval16), 64'(e.tval));
    check("d16.instret", 64'(ir16), e.ir & 64'hF);
    idle();
  endtask
  task automatic check_reset(input string tag);
    check({tag, ".pc32"}, 64'(pc32), 0);
    check({tag, ".pv32"}, 64'(pv32), 0);
    check({tag, ".tv32"}, 64'(tv32), 0);
    check({tag, ".tc32"}, 64'(tc32), 0);
    check({tag, ".epc32"}, 64'(epc32), 0);
    check({tag, ".tval32"}, 64'(tval32), 0);
    check({tag, ".ir32"}, ir32, 0);
    check({tag, ".pc16"}, 64'(pc16), 0);
    check({tag, ".tv16"}, 64'(tv16), 0);
    check({tag, ".ir16"}, 64'(ir16), 0);
  endtask
  initial begin
    idle();
    m32 = '0; m16 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    rst_n = 1;
    #1;
    check("boot.pc", 64'(pc32), 0);
    check("boot.valid", 64'(pv32), 0);
    step();
    check("run.valid", 64'(pv32), 1);
    check("run.pc", 64'(pc32), 0);
    step();
    check("seq.pc", 64'(pc32), 32'h4);
    check("seq.instret", ir32, 1);
    step();
    is_jal = 1; imm_out = 32'h10; step();
    check("jal.pc", 64'(pc32), 32'h18);
    is_branch = 1; imm_out = 32'h3; step();
    check("untaken.pc", 64'(pc32), 32'h1C);
    is_jal = 1; imm_out = -32'sd4; step();
    is_branch = 1; branch_taken = 1; imm_out = -32'sd8; step();
    check("taken.pc", 64'(pc32), 32'h10);
    is_jalr = 1; rs1_data = 32'h21; imm_out = 32'h4; step();
    check("jalr.pc", 64'(pc32), 32'h24);
    is_jalr = 1; rs1_data = 32'h40; step();
    is_jal = 1; imm_out = 32'h6; step();
    check("mis.pc", 64'(pc32), 32'h100);
    check("mis.trap_valid", 64'(tv32), 1);
    check("mis.cause", 64'(tc32), 0);
    check("mis.epc", 64'(epc32), 32'h40);
    check("mis.tval", 64'(tval32), 32'h46);
    check("mis.instret", ir32, 8);
    check("c16.pc", 64'(pc16), 32'h46);
    check("c16.no_trap", 64'(tv16), 0);
    is_compressed = 1; step();
    check("mis.pulse_end", 64'(tv32), 0);
    check("c16.step2", 64'(pc16), 32'h48);
    trap_ret = 1; trap_ret_pc = 32'h44; step();
    check("ret.pc", 64'(pc32), 32'h44);
    for (int i = 0; i < 3; i++) begin
      stall = 1; is_jal = 1; imm_out = 32'h8; step();
      check("stall.pc", 64'(pc32), 32'h44);
      check("stall.instret", ir32, 9);
    end
    stall = 1; trap_req = 1; trap_req_cause = 4'd2; step();
    check("treq.pc", 64'(pc32), 32'h100);
    check("treq.cause", 64'(tc32), 2);
    check("treq.epc", 64'(epc32), 32'h44);
    check("treq.tval", 64'(tval32), 0);
    rst_n = 0;
    #1;
    check_reset("async_rst");
    m32 = '0; m16 = '0;
    @(negedge clk);
    rst_n = 1;
    step();
    is_jalr = 1; rs1_data = 32'hFFFF_FFF8; imm_out = 32'h4; step();
    check("top.pc", 64'(pc32), 32'hFFFF_FFFC);
    step();
    check("wrap.pc", 64'(pc32), 0);
    check("wrap.no_trap", 64'(tv32), 0);
    repeat (14) step();
    check("cnt.wrap16", 64'(ir16), 0);
    check("cnt.full", ir32, 16);
    for (int i = 0; i < 300; i++) begin
      stall         = $urandom_range(0, 3) == 0;
      trap_req      = $urandom_range(0, 15) == 0;
      trap_req_cause = 4'($urandom_range(1, 15));
      trap_ret      = $urandom_range(0, 7) == 0;
      trap_ret_pc   = $urandom;
      is_branch     = $urandom_range(0, 3) == 0;
      branch_taken  = $urandom_range(0, 1) == 1;
      is_jal        = $urandom_range(0, 5) == 0;
      is_jalr       = $urandom_range(0, 5) == 0;
      is_compressed = $urandom_range(0, 1) == 1;
      imm_out       = 32'(int'($urandom_range(0, 127)) - 64);
      rs1_data      = $urandom;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter unit: holds the architectural PC, selects the next PC (sequential / branch / JAL / JALR / trap / trap-return), and detects instruction-address misalignment as a precise trap instead of a simulation stop.
- Sits at the front of the core: drives the fetch address, consumes decode/branch-unit control, and feeds trap state to the CSR block.
- Generalises the combinational next-PC mux with a reset vector, stall, 16/32-bit alignment modes, trap entry/return and a retired-instruction counter.

Parameters:
DATA_WIDTH, 32, PC/operand width
RESET_VECTOR, 32'h0000_0000, PC loaded at reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap entry
IALIGN, 32, 32 = word-aligned only; 16 = compressed enabled (halfword alignment, +2 step)
CNT_WIDTH, 64, width of retired-instruction counter

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
stall  in  1  hold PC; blocks all advances except trap_req
is_branch  in  1  current instr is conditional branch
branch_taken  in  1  branch condition true
is_jal  in  1  current instr is JAL
is_jalr  in  1  current instr is JALR
is_compressed  in  1  current instr is 16-bit; ignored when IALIGN=32
imm_out  in  DATA_WIDTH  B/J offset (already shifted); JALR immediate
rs1_data  in  DATA_WIDTH  JALR base
trap_req  in  1  external synchronous exception (illegal, ecall, ...)
trap_req_cause  in  4  cause code for trap_req
trap_ret  in  1  MRET-class return
trap_ret_pc  in  DATA_WIDTH  return target (from mepc)
pc  out  DATA_WIDTH  current fetch PC
pc_valid  out  1  pc holds a real instruction
trap_valid  out  1  one-cycle trap-entry pulse
trap_cause  out  4  0 = instr addr misaligned, else trap_req_cause
trap_epc  out  DATA_WIDTH  PC of faulting instruction
trap_tval  out  DATA_WIDTH  faulting target (misalign) or 0
instret  out  CNT_WIDTH  count of retired instructions

Behaviour:
- Clock clk; reset asynchronous, active-low on rst_n. Reset: pc=RESET_VECTOR, pc_valid=0, trap_valid=0, trap_cause=0, trap_epc=0, trap_tval=0, instret=0, state=BOOT. Reset mid-operation discards any pending trap.
- States: BOOT (pc_valid=0, inputs ignored) -> RUN after 1 cycle, pc unchanged. RUN (pc_valid=1). TRAP (pc_valid=0, trap_valid=1, inputs ignored) -> RUN after exactly 1 cycle.
- Combinational targets: seq = pc+4 (pc+2 if IALIGN=16 and is_compressed); br = pc+imm_out; jalr = (rs1_data+imm_out) with bit0 cleared. All sums modulo 2^DATA_WIDTH; wrap at the top of the address space is legal, not a trap.
- Misaligned: chosen non-sequential target has bits[1:0]!=0 (IALIGN=32) or bit0!=0 (IALIGN=16). Untaken branch never checks its target.
- RUN priority at each edge:
  1. trap_req (even if stall): pc<=TRAP_VECTOR, cause=trap_req_cause, epc=pc, tval=0, ->TRAP.
  2. stall: pc, state, instret hold.
  3. trap_ret: pc<=trap_ret_pc (bit0 cleared; bit1 also cleared if IALIGN=32), instret+1.
  4. jalr / jal / taken branch (that order) with misaligned target: pc<=TRAP_VECTOR, cause=0, epc=pc, tval=raw target, ->TRAP; instret not incremented.
  5. jalr / jal / taken branch aligned: pc<=target, instret+1.
  6. else pc<=seq, instret+1.
- trap_cause/epc/tval update only on trap entry and hold until the next trap. trap_valid is registered: high during the TRAP cycle only.
- instret wraps to 0 at 2^CNT_WIDTH.
- Conflicting control flags (e.g. is_jal and is_jalr): resolved by the priority above; no error raised.

Decomposition:
- Shared defines file holds DATA_WIDTH, the state encoding (BOOT/RUN/TRAP, 2 bits) and the trap cause constants (CAUSE_INSTR_MISALIGN=0).
- Sub-module next_pc_sel: combinational target and misalign computation (inputs pc, imm, rs1, flags; outputs target, take, misalign). The parent owns state, PC register, trap registers and counter.

Test Plan:
- Reset release: rst_n 0->1 -> cycle 0 pc=0x0 pc_valid=0; cycle 1 pc_valid=1; cycle 2 pc=0x4; instret=1.
- JAL imm=0x10 at pc=0x8 -> pc=0x18. JALR rs1=0x21 imm=0x4 -> pc=0x24. Taken branch imm=-8 at pc=0x18 -> pc=0x10. Untaken -> pc=0x1C.
- Misalign, IALIGN=32: JAL imm=0x6 at pc=0x40 -> pc=0x100, trap_valid pulse 1 cycle, cause=0, epc=0x40, tval=0x46, instret unchanged. Same with IALIGN=16 -> pc=0x46, no trap; is_compressed at 0x46 -> pc=0x48.
- stall=1 for 3 cycles with is_jal -> pc and instret frozen. trap_req with stall=1, cause=2 -> pc=0x100, epc=stalled pc, tval=0.
- trap_ret with trap_ret_pc=0x44 one cycle after TRAP -> pc=0x44. rst_n asserted during the TRAP cycle -> all outputs return to reset values asynchronously.
- Wrap: pc=0xFFFF_FFFC sequential -> pc=0x0, no trap. instret with CNT_WIDTH=4 after 16 retires -> 0.
